pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Consumer side of the hazard unit: takes hazard/branch/jump verdicts plus cache handshakes and drives
//  per-latch enable/flush, PC enable and redirect select for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Sits between hazard unit, caches and pipeline latches; owns freeze/bubble/squash sequencing, halt
//  latching and stall/flush performance counters.
// PARAMETERS
//  CNTW      32  width of stall_cnt / flush_cnt (saturating)
// PORTS
//  CLK          in   1     clock, rising edge
//  RST          in   1     asynchronous, active-high reset
//  hazard       in   1     load-use hazard in ID (from hazard unit)
//  branch       in   1     taken branch resolved in ID
//  jump         in   1     jump resolved in ID
//  ihit         in   1     instruction fetch complete this cycle
//  dhit         in   1     data access complete this cycle
//  mem_req      in   1     MEM stage holds dmemREN|dmemWEN
//  mem_halt     in   1     HALT instruction has reached MEM
//  pc_en        out  1     PC register update enable
//  pc_redirect  out  1     PC selects branch/jump target
//  ifid_en      out  1     IF/ID latch enable;  ifid_flush   out 1  IF/ID clear to NOP
//  idex_en      out  1     ID/EX latch enable;  idex_flush   out 1  ID/EX clear to NOP
//  exmem_en     out  1     EX/MEM latch enable; exmem_flush  out 1  EX/MEM clear to NOP
//  memwb_en     out  1     MEM/WB latch enable
//  halted       out  1     sticky halt indication
//  stall_cnt    out  CNTW  cycles lost to load-use bubbles
//  flush_cnt    out  CNTW  number of taken redirects
// BEHAVIOUR
//  Reset (async, RST=1): state=RUN, redir_pend=0, counters=0; while RST high all enables/flushes=0, halted=0.
//  adv = mem_req ? dhit : ihit  (pipeline may move this cycle). Outputs combinational from state+inputs;
//  state, redir_pend, counters update on rising CLK.
//  States: RUN, MEMWAIT, HALT.
//   RUN: mem_halt -> HALT. Else mem_req & ~dhit -> MEMWAIT. Else stay.
//   MEMWAIT: all en=0, flush=0, pc_en=0; dhit -> RUN (that same cycle behaves as RUN with adv=1).
//   HALT: all en/flush/pc_en=0, halted=1; leaves only via reset. mem_halt has priority over every event.
//  In RUN with adv=0: every en=0, every flush=0 (full freeze, no bubble inserted).
//  In RUN with adv=1, priority hazard > branch/jump > normal:
//   hazard: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; pc_redirect=0 (redirect ignored).
//   branch|jump: pc_en=1, pc_redirect=1, ifid_flush=1, remaining en=1.
//   normal: all en=1, no flush, pc_redirect=0.
//  Redirect during freeze: branch|jump in RUN/MEMWAIT with adv=0 and hazard=0 sets redir_pend=1
//   (inputs are held stable by the frozen latches). redir_pend forces ifid_flush=1 on the next adv cycle,
//   then clears. redir_pend set and clear same cycle -> clear wins.
//  Flush and en on one latch: flush dominates (latch loads NOP).
//  exmem_flush is tied 0 in this revision; driven for future MEM-stage squash.
//  Counters: stall_cnt += 1 on each RUN&adv&hazard cycle; flush_cnt += 1 on each RUN&adv&~hazard&
//   (branch|jump) cycle; both saturate at 2^CNTW-1 (no wrap); frozen while halted.
// TESTING
//  1 Reset mid-run: RST pulse while MEMWAIT -> outputs 0 immediately (async), state RUN, counters 0.
//  2 Load-use: ihit=1, hazard=1 one cycle -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
//  3 Taken branch, ihit=1 -> pc_redirect=1, ifid_flush=1; flush_cnt 0->1; next cycle normal.
//  4 Data miss: mem_req=1, dhit=0 for 3 cycles then 1 -> 3 cycles all en=0, then one cycle all en=1.
//  5 Branch with ihit=0 for 2 cycles, then ihit=1 -> redir_pend set, ifid_flush=1 on the ihit cycle only.
//  6 hazard & branch together -> bubble only, pc_redirect=0; mem_halt=1 -> halted=1, stays 1 for 10 cycles.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Consumer side of the hazard unit for a 5-stage (IF/ID/EX/MEM/WB)
//             pipeline. It takes the hazard, branch and jump verdicts and the
//             cache handshakes, and drives the per-latch enables and flushes,
//             the PC enable and the redirect select. It also latches HALT and
//             keeps the stall and flush performance counters.
//  Ports    : clk, rst (async, active-high)
//             hazard, branch, jump         - verdicts resolved in ID
//             ihit, dhit                   - fetch / data access complete
//             mem_req, mem_halt            - MEM-stage access / HALT in MEM
//             pc_en, pc_redirect           - PC update / take target
//             ifid_en/flush, idex_en/flush, exmem_en/flush, memwb_en
//             halted                       - sticky halt indication
//             stall_cnt, flush_cnt         - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hazard,
    input  logic            branch,
    input  logic            jump,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_req,
    input  logic            mem_halt,
    output logic            pc_en,
    output logic            pc_redirect,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic            halted,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_MEMWAIT = 2'd1;
    localparam logic [1:0] c_HALT    = 2'd2;

    localparam logic [CNTW-1:0] c_CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_redir_pend;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    logic w_adv;
    logic w_go;
    logic w_redir;
    logic w_live;
    logic w_pend_set;

    assign w_adv   = mem_req ? dhit : ihit;
    assign w_redir = branch | jump;
    assign w_live  = (r_state == c_RUN) || (r_state == c_MEMWAIT);

    // The cycle that completes a data miss is treated exactly like a RUN cycle
    // in which the pipeline advances.
    assign w_go = ((r_state == c_RUN) && w_adv) ||
                  ((r_state == c_MEMWAIT) && dhit);

    // A redirect seen while frozen is remembered; the frozen latches keep the
    // branch/jump inputs stable, but the IF/ID flush must not be lost if a
    // hazard happens to win the advancing cycle.
    assign w_pend_set = w_live && !w_go && !hazard && w_redir;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; mem_halt outranks every other event
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_RUN: begin
                if (mem_halt)                w_next = c_HALT;
                else if (mem_req && !dhit)   w_next = c_MEMWAIT;
                else                         w_next = c_RUN;
            end
            c_MEMWAIT: begin
                if (mem_halt)                w_next = c_HALT;
                else if (dhit)               w_next = c_RUN;
                else                         w_next = c_MEMWAIT;
            end
            c_HALT:                          w_next = c_HALT;
            default:                         w_next = c_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic; everything stays low while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;   // reserved for a future MEM-stage squash
        memwb_en    = 1'b0;
        halted      = (r_state == c_HALT) && !rst;

        if (!rst && w_go) begin
            if (hazard) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (w_redir) begin
                pc_en       = 1'b1;
                pc_redirect = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
            if (r_redir_pend) begin
                ifid_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending redirect and saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redir_pend <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_go) begin
                r_redir_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_redir_pend <= 1'b1;
            end

            if (w_go && hazard && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_go && !hazard && w_redir && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
